pad_poll_sequencer: RTL

Sequences the serial game-pad port driven by `controller`. The block issues the latch pulse on `contWrite` and the shift clock on `contCLK`, and samples `contRead` one bit per clock pulse. At the end of each poll it presents a parallel, active-high button word with a one-cycle valid strobe. Polls run either on request or automatically at a fixed frame rate, and the block sits between the pad pins and the fabric logic that consumes button state.

---
 rtl/pad_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pad_poll_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the game-pad poll sequencer: FSM encoding and default timing constants.
package pad_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLatch = 3'd1,
        StLow   = 3'd2,
        StHigh  = 3'd3,
        StDone  = 3'd4
    } pad_state_e;

    localparam int unsigned NumBitsDefault = 16;
    localparam int unsigned ClkDivDefault  = 60;
    localparam int unsigned PollDivDefault = 166667;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 so an idle pad reads as released.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pad_poll_sequencer.sv
// Serial game-pad poller: latch pulse, NUM_BITS shift-clock pulses, parallel active-high button word.
module pad_poll_sequencer
    import pad_pkg::*;
#(
    parameter int unsigned NUM_BITS = NumBitsDefault,
    parameter int unsigned CLK_DIV  = ClkDivDefault,
    parameter int unsigned POLL_DIV = PollDivDefault
) (
    input  logic                SYSCLK,
    input  logic                SYSRESET,
    input  logic                start,
    input  logic                auto_en,
    input  logic                contRead,
    output logic                contCLK,
    output logic                contWrite,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned PhW  = $clog2(2 * CLK_DIV);
    localparam int unsigned IdxW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned TmW  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    localparam logic [PhW-1:0]  PhHalfLast = PhW'(CLK_DIV - 1);
    localparam logic [PhW-1:0]  PhFullLast = PhW'(2 * CLK_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(NUM_BITS - 1);
    localparam logic [TmW-1:0]  TmLast     = TmW'(POLL_DIV - 1);

    pad_state_e          state_q;
    logic [PhW-1:0]      phase_q;
    logic [IdxW-1:0]     idx_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [TmW-1:0]      timer_q;
    logic                rd_sync;
    logic                rd_s;
    logic                auto_tick;

    sync_2ff u_sync (
        .clk (SYSCLK),
        .rst (SYSRESET),
        .d   (contRead),
        .q   (rd_sync)
    );

    // Pad data is active-low; invert once so everything downstream is active-high.
    assign rd_s = ~rd_sync;

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET || timer_q == TmLast) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign auto_tick = auto_en & (timer_q == TmLast);

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            buttons   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            contCLK   <= 1'b1;
            contWrite <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start || auto_tick) begin
                        state_q   <= StLatch;
                        phase_q   <= '0;
                        contWrite <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StLatch: begin
                    if (phase_q == PhFullLast) begin
                        state_q   <= StLow;
                        phase_q   <= '0;
                        idx_q     <= '0;
                        contWrite <= 1'b0;
                        contCLK   <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StLow: begin
                    // Sample as late as possible so sync latency and pad settling fit in the phase.
                    if (phase_q == PhHalfLast) begin
                        shift_q[idx_q] <= rd_s;
                        state_q        <= StHigh;
                        phase_q        <= '0;
                        contCLK        <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (phase_q == PhHalfLast) begin
                        phase_q <= '0;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == IdxLast) begin
                            state_q <= StDone;
                            buttons <= shift_q;
                            valid   <= 1'b1;
                        end else begin
                            state_q <= StLow;
                            contCLK <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
